// File: rtl/cmp_vec_checker.sv
// Exhaustive stimulus-and-check engine for a domino equality comparator.
// It sweeps every (A,B) pair, samples cmp_out after LATENCY cycles and tallies mismatches.
module cmp_vec_checker #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cmp_out,
  output logic [WIDTH-1:0]   a_drv,
  output logic [WIDTH-1:0]   b_drv,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH:0]   err_cnt,
  output logic [2*WIDTH:0]   eq_cnt,
  output logic               first_fail,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
);

  localparam int IW = 2 * WIDTH;
  localparam int CW = IW + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRIVE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [2:0]    WAIT_LOAD = 3'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);

  logic [2:0]    r_state;
  logic [IW-1:0] r_idx;
  logic          r_expect;
  logic [2:0]    r_wait;

  logic w_mismatch;
  logic w_last;

  assign w_mismatch = (cmp_out != r_expect);
  assign w_last     = (r_idx == {IW{1'b1}});

  // NOTE: every state element is updated with <= so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_expect   <= 1'b0;
      r_wait     <= '0;
      a_drv      <= '0;
      b_drv      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_cnt    <= '0;
      eq_cnt     <= '0;
      first_fail <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            err_cnt    <= '0;
            eq_cnt     <= '0;
            first_fail <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            r_idx      <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
            r_state    <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          a_drv    <= r_idx[IW-1:WIDTH];
          b_drv    <= r_idx[WIDTH-1:0];
          r_expect <= (r_idx[IW-1:WIDTH] == r_idx[WIDTH-1:0]);
          r_wait   <= WAIT_LOAD;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          // Operands stay frozen here so the comparator's precharge/evaluate window sees stable inputs.
          if (r_wait == 3'd0) r_state <= S_CHECK;
          else                r_wait  <= r_wait - 3'd1;
        end
        S_CHECK: begin
          if (r_expect && (eq_cnt != {CW{1'b1}})) eq_cnt <= eq_cnt + CNT_ONE;
          if (w_mismatch) begin
            if (err_cnt != {CW{1'b1}}) err_cnt <= err_cnt + CNT_ONE;
            if (!first_fail) begin
              first_fail <= 1'b1;
              fail_a     <= a_drv;
              fail_b     <= b_drv;
            end
          end
          if (w_last) begin
            r_state <= S_FIN;
          end else begin
            r_idx   <= r_idx + IDX_ONE;
            r_state <= S_DRIVE;
          end
        end
        S_FIN: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_vec_checker.sv
// Bench for cmp_vec_checker: behavioural comparator models with injectable faults,
// a table of full sweeps plus hand-written restart/reset/latency sequences.
module tb_cmp_vec_checker;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance with LATENCY=1 and a selectable comparator model
  logic         start1, cmp1;
  logic [W-1:0] a1, b1, fa1, fb1;
  logic         busy1, done1, ff1;
  logic [2*W:0] err1, eq1;

  // Instance with LATENCY=3 driven by a 3-cycle comparator
  logic         start3, cmp3;
  logic [W-1:0] a3, b3, fa3, fb3;
  logic         busy3, done3, ff3;
  logic [2*W:0] err3, eq3;

  cmp_vec_checker #(.WIDTH(W), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cmp_out(cmp1),
    .a_drv(a1), .b_drv(b1), .busy(busy1), .done(done1),
    .err_cnt(err1), .eq_cnt(eq1), .first_fail(ff1), .fail_a(fa1), .fail_b(fb1)
  );

  cmp_vec_checker #(.WIDTH(W), .LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .cmp_out(cmp3),
    .a_drv(a3), .b_drv(b3), .busy(busy3), .done(done3),
    .err_cnt(err3), .eq_cnt(eq3), .first_fail(ff3), .fail_a(fa3), .fail_b(fb3)
  );

  // Comparator models: 0 good 1-cycle, 1 stuck-0, 2 stuck-1, 3 inverted, 4 good 3-cycle
  int   mode;
  logic p1, p2, p3, q1, q2, q3;

  always_ff @(posedge clk) begin
    p1 <= (a1 == b1);
    p2 <= p1;
    p3 <= p2;
    q1 <= (a3 == b3);
    q2 <= q1;
    q3 <= q2;
  end

  always_comb begin
    cmp1 = p1;
    case (mode)
      1:       cmp1 = 1'b0;
      2:       cmp1 = 1'b1;
      3:       cmp1 = ~p1;
      4:       cmp1 = p3;
      default: cmp1 = p1;
    endcase
  end
  assign cmp3 = q3;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a_drv"},      int'(a1),    0);
    check({tag, "_b_drv"},      int'(b1),    0);
    check({tag, "_busy"},       int'(busy1), 0);
    check({tag, "_done"},       int'(done1), 0);
    check({tag, "_err_cnt"},    int'(err1),  0);
    check({tag, "_eq_cnt"},     int'(eq1),   0);
    check({tag, "_first_fail"}, int'(ff1),   0);
    check({tag, "_fail_a"},     int'(fa1),   0);
    check({tag, "_fail_b"},     int'(fb1),   0);
  endtask

  task automatic set_start(input bit sel, input bit v);
    if (sel) start3 = v;
    else     start1 = v;
  endtask

  // Starts a sweep and counts clock edges after the start edge until done rises.
  // Start is held for `hold` edges and re-pulsed for the edges after counts p0/p1.
  task automatic run_sweep(input bit sel, input int hold, input int p0, input int p1,
                           output int cyc, output bit busy_ok);
    int n;
    bit dn, bz;
    busy_ok = 1'b1;
    set_start(sel, 1'b1);
    @(negedge clk);
    n  = 0;
    bz = sel ? busy3 : busy1;
    if (!bz) busy_ok = 1'b0;
    dn = 1'b0;
    while (!dn && n < 3000) begin
      set_start(sel, (n < hold - 1) || (n == p0) || (n == p1));
      @(negedge clk);
      n++;
      dn = sel ? done3 : done1;
      bz = sel ? busy3 : busy1;
      if (!dn && !bz) busy_ok = 1'b0;
    end
    set_start(sel, 1'b0);
    cyc = n;
  endtask

  typedef struct {
    string name;
    int    mode;
    int    exp_err;
    int    exp_eq;
    int    exp_ff;
    int    exp_fa;
    int    exp_fb;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int cyc;
    bit bok;

    vecs[0] = '{"good",     0,   0, 16, 0, 0, 0};
    vecs[1] = '{"stuck0",   1,  16, 16, 1, 0, 0};
    vecs[2] = '{"stuck1",   2, 240, 16, 1, 0, 1};
    vecs[3] = '{"inverted", 3, 256, 16, 1, 0, 0};
    // 3-cycle comparator on a 1-cycle checker sees the previous vector's result:
    // mismatch at every change of A==B between consecutive vectors (30 of them), first at (0,1)
    vecs[4] = '{"late3",    4,  30, 16, 1, 0, 1};

    mode   = 0;
    start1 = 1'b0;
    start3 = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      mode = vecs[i].mode;
      repeat (4) @(negedge clk);
      run_sweep(1'b0, 1, -1, -1, cyc, bok);
      check({vecs[i].name, "_cycles"},     cyc,        769);
      check({vecs[i].name, "_busy_held"},  int'(bok),  1);
      check({vecs[i].name, "_err_cnt"},    int'(err1), vecs[i].exp_err);
      check({vecs[i].name, "_eq_cnt"},     int'(eq1),  vecs[i].exp_eq);
      check({vecs[i].name, "_first_fail"}, int'(ff1),  vecs[i].exp_ff);
      check({vecs[i].name, "_fail_a"},     int'(fa1),  vecs[i].exp_fa);
      check({vecs[i].name, "_fail_b"},     int'(fb1),  vecs[i].exp_fb);
    end

    // Held start, start at vector 50 and start during FIN are all ignored
    mode = 0;
    run_sweep(1'b0, 3, 150, 768, cyc, bok);
    check("extra_start_cycles",  cyc,        769);
    check("extra_start_busy",    int'(bok),  1);
    check("extra_start_err_cnt", int'(err1), 0);
    check("extra_start_eq_cnt",  int'(eq1),  16);
    @(negedge clk);
    check("fin_start_busy", int'(busy1), 0);
    check("fin_start_done", int'(done1), 1);
    repeat (3) @(negedge clk);
    check("done_sticky", int'(done1), 1);

    // Accepted start after done clears done and counts on the next cycle
    mode   = 1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("restart_done",   int'(done1), 0);
    check("restart_busy",   int'(busy1), 1);
    check("restart_eq_cnt", int'(eq1),   0);
    check("restart_err",    int'(err1),  0);

    // Asynchronous reset near vector 100 of a failing sweep
    repeat (300) @(negedge clk);
    check("pre_reset_err_nonzero", int'(err1 != '0), 1);
    #2 rst_n = 1'b0;
    #1 check_zero("mid_reset");
    start1 = 1'b1;
    repeat (2) @(negedge clk);
    start1 = 1'b0;
    rst_n  = 1'b1;
    repeat (2) @(negedge clk);
    check("start_in_reset_busy", int'(busy1), 0);

    mode = 0;
    run_sweep(1'b0, 1, -1, -1, cyc, bok);
    check("post_reset_cycles",  cyc,        769);
    check("post_reset_err_cnt", int'(err1), 0);
    check("post_reset_eq_cnt",  int'(eq1),  16);

    // LATENCY=3 checker against a matching 3-cycle comparator
    run_sweep(1'b1, 1, -1, -1, cyc, bok);
    check("lat3_cycles",     cyc,        1281);
    check("lat3_busy_held",  int'(bok),  1);
    check("lat3_err_cnt",    int'(err3), 0);
    check("lat3_eq_cnt",     int'(eq3),  16);
    check("lat3_first_fail", int'(ff3),  0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cmp_vec_checker.md
Name: cmp_vec_checker

Overview:
- Sequential stimulus-and-check engine for the 4-bit domino equality comparator `cmp` (ports clk, A, B, out).
- On `start`, it sweeps every operand pair exhaustively and drives them into the comparator's A/B inputs.
- After a fixed latency it samples the comparator's `out` and compares it against a registered golden A==B.
- It reports pass/mismatch/equal counts and the first failing pair, so on-chip or bench self-test needs no hand-written vector lists.

Parameters:
- WIDTH, 4, operand width; the sweep covers 2^(2*WIDTH) pairs.
- LATENCY, 1, clk cycles from operand drive to a valid comparator `out`. Legal range 1..7.

Ports:
- clk  in  1  system clock; also the domino precharge/evaluate clock shared with `cmp`.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a sweep; ignored while busy=1.
- cmp_out  in  1  comparator result; 1 means A==B.
- a_drv  out  WIDTH  operand to comparator A.
- b_drv  out  WIDTH  operand to comparator B.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; sticky until the next accepted start or reset.
- err_cnt  out  2*WIDTH+1  number of mismatches.
- eq_cnt  out  2*WIDTH+1  number of vectors where golden A==B.
- first_fail  out  1  at least one mismatch recorded.
- fail_a  out  WIDTH  A operand of the first mismatch.
- fail_b  out  WIDTH  B operand of the first mismatch.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State is IDLE.
  - a_drv, b_drv, busy, done, err_cnt, eq_cnt, first_fail, fail_a and fail_b are all 0.
  - The vector index idx (2*WIDTH bits) is 0.
  - Reset mid-sweep aborts the sweep immediately. No counts are retained and done is not asserted.
- Vector order: a_drv = idx[2W-1:W], b_drv = idx[W-1:0]. idx increments from 0 to 2^(2W)-1, so the order is (0,0), (0,1) … (15,15).
- FSM states: IDLE, DRIVE, WAIT, CHECK, FIN.
- IDLE:
  - When start=1: clear err_cnt, eq_cnt, first_fail, fail_a, fail_b, idx and done; set busy=1; go to DRIVE.
- DRIVE (1 cycle):
  - Register a_drv/b_drv from idx.
  - Register golden expect = (idx_a == idx_b).
  - Load the wait counter with LATENCY-1; go to WAIT.
- WAIT:
  - Hold operands stable.
  - When the wait counter reaches 0, go to CHECK; otherwise decrement.
  - With LATENCY=1, WAIT lasts exactly 1 cycle.
- CHECK (1 cycle):
  - Sample cmp_out.
  - If expect=1, increment eq_cnt.
  - On a mismatch (cmp_out != expect): increment err_cnt. If first_fail=0, set first_fail=1 and capture fail_a=a_drv, fail_b=b_drv.
  - If idx is all-ones, go to FIN; otherwise increment idx and go to DRIVE.
- FIN (1 cycle): busy=0, done=1, then go to IDLE. done stays 1 in IDLE.
- Timing:
  - Per-vector cost is 2+LATENCY cycles.
  - A sweep takes 2^(2W)*(2+LATENCY)+1 cycles from the start edge to done rising. For W=4, L=1 that is 769 cycles.
- Operand stability: operands never change during WAIT or CHECK, which respects the domino precharge/evaluate window.
- Counters saturate at their maximum and never wrap. They are sized for the full sweep, so saturation only guards against a parameter misuse.
- Simultaneous events:
  - start in the same cycle as FIN is ignored.
  - A start pulse held for several cycles starts only one sweep.
  - start asserted during reset has no effect.

Test Plan:
1. Behavioural cmp model (out = A==B), LATENCY=1; pulse start → busy for the full sweep, done rises 769 cycles later; err_cnt=0, eq_cnt=16, first_fail=0.
2. cmp_out stuck at 0 → err_cnt=16, eq_cnt=16, first_fail=1, fail_a=0, fail_b=0.
3. cmp_out stuck at 1 → err_cnt=240, fail_a=0, fail_b=1. Inverted model → err_cnt=256, fail_a=0, fail_b=0.
4. Assert rst_n=0 at vector 100 → all outputs 0 asynchronously, state IDLE. A fresh start then completes with err_cnt=0, eq_cnt=16.
5. Pulse start at vector 50 and again in the cycle done rises → both ignored; a single sweep with unchanged results. A start after done → done clears and counts clear the next cycle.
6. LATENCY=3, model with 3-cycle delay → err_cnt=0; done after 256*5+1=1281 cycles. The same model with LATENCY=1 → err_cnt>0.
